// File: rtl/sensor_pkg.sv
// Shared definitions for the sensor readout path (sequencer, pixel row, SAR ADC).
package sensor_pkg;

  localparam int DEF_WIDTH      = 2;
  localparam int DEF_RESOLUTION = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERASE,
    ST_EXPOSE,
    ST_SETTLE,
    ST_ADC_CLR,
    ST_CONVERT,
    ST_OUTPUT,
    ST_DONE
  } seq_state_t;

  // Width of a down-counter that is loaded with max_val-1 and counts to zero.
  function automatic int cnt_w(input int max_val);
    return (max_val > 2) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/pixel_readout_sequencer_if.sv
// Pixel sample stream from the sequencer to the downstream consumer.
interface pixel_readout_sequencer_if #(
  parameter int WIDTH      = 2,
  parameter int RESOLUTION = 8
) ();

  logic [RESOLUTION-1:0] pixel_data;
  logic [WIDTH:0]        pixel_index;
  logic                  pixel_error;
  logic                  pixel_valid;
  logic                  pixel_ready;

  modport master (
    output pixel_data, pixel_index, pixel_error, pixel_valid,
    input  pixel_ready
  );

  modport slave (
    input  pixel_data, pixel_index, pixel_error, pixel_valid,
    output pixel_ready
  );

endinterface

// File: rtl/pixel_readout_sequencer_cycle_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load)
      count_d = load_val;
    else if (en && count_q != '0)
      count_d = count_q - W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/pixel_readout_sequencer.sv
// Frame sequencer: erase, expose, then per pixel select/settle, ADC clear, convert
// (with timeout) and hand the sample downstream; all outputs come straight from flops.
module pixel_readout_sequencer
  import sensor_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int ROWS          = 2,
  parameter int RESOLUTION    = DEF_RESOLUTION,
  parameter int ERASE_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int ADC_TIMEOUT   = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [15:0]           expose_time,
  output logic                  ERASE,
  output logic                  EXPOSE,
  output logic [WIDTH:0]        decoder_select,
  output logic                  adc_reset,
  output logic                  adc_enable,
  input  logic [RESOLUTION-1:0] adc_output,
  input  logic                  adc_done,
  pixel_readout_sequencer_if.master pix,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int IW   = WIDTH + 1;
  localparam int ER_W = cnt_w(ERASE_CYCLES);
  localparam int SE_W = cnt_w(SETTLE_CYCLES);
  localparam int TO_W = cnt_w(ADC_TIMEOUT);

  seq_state_t state_q, state_d;

  logic [IW-1:0]         idx_q, idx_d;
  logic [RESOLUTION-1:0] data_q, data_d;
  logic [IW-1:0]         pidx_q, pidx_d;
  logic                  err_q, err_d;

  logic start_ld, settle_ld, tmo_ld;
  logic erase_end, expose_end, settle_end, tmo_end;
  logic [15:0] expose_ld_val;

  logic          erase_q, erase_d;
  logic          expose_q, expose_d;
  logic [IW-1:0] dsel_q, dsel_d;
  logic          adc_reset_q, adc_reset_d;
  logic          adc_enable_q, adc_enable_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;

  // A zero exposure request still gets one EXPOSE cycle.
  assign expose_ld_val = (expose_time == 16'd0) ? 16'd0 : expose_time - 16'd1;

  cycle_timer #(.W(ER_W)) u_erase_tmr (
    .clk(clk), .reset(reset), .load(start_ld),
    .load_val(ER_W'(ERASE_CYCLES - 1)),
    .en(state_q == ST_ERASE), .done(erase_end)
  );

  cycle_timer #(.W(16)) u_expose_tmr (
    .clk(clk), .reset(reset), .load(start_ld),
    .load_val(expose_ld_val),
    .en(state_q == ST_EXPOSE), .done(expose_end)
  );

  cycle_timer #(.W(SE_W)) u_settle_tmr (
    .clk(clk), .reset(reset), .load(settle_ld),
    .load_val(SE_W'(SETTLE_CYCLES - 1)),
    .en(state_q == ST_SETTLE), .done(settle_end)
  );

  cycle_timer #(.W(TO_W)) u_timeout_tmr (
    .clk(clk), .reset(reset), .load(tmo_ld),
    .load_val(TO_W'(ADC_TIMEOUT - 1)),
    .en(state_q == ST_CONVERT), .done(tmo_end)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    pidx_d    = pidx_q;
    err_d     = err_q;
    start_ld  = 1'b0;
    settle_ld = 1'b0;
    tmo_ld    = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        start_ld = 1'b1;
        idx_d    = '0;
        state_d  = ST_ERASE;
      end
      ST_ERASE:  if (erase_end) state_d = ST_EXPOSE;
      ST_EXPOSE: if (expose_end) begin
        settle_ld = 1'b1;
        state_d   = ST_SETTLE;
      end
      ST_SETTLE: if (settle_end) state_d = ST_ADC_CLR;
      ST_ADC_CLR: begin
        tmo_ld  = 1'b1;
        state_d = ST_CONVERT;
      end
      ST_CONVERT: begin
        // done on the terminal timeout cycle still counts as a real sample
        if (adc_done) begin
          data_d  = adc_output;
          err_d   = 1'b0;
          pidx_d  = idx_q;
          state_d = ST_OUTPUT;
        end else if (tmo_end) begin
          data_d  = '0;
          err_d   = 1'b1;
          pidx_d  = idx_q;
          state_d = ST_OUTPUT;
        end
      end
      ST_OUTPUT: if (pix.pixel_ready) begin
        if (idx_q == IW'(ROWS - 1)) begin
          state_d = ST_DONE;
        end else begin
          idx_d     = idx_q + IW'(1);
          settle_ld = 1'b1;
          state_d   = ST_SETTLE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    erase_d      = (state_d == ST_ERASE);
    expose_d     = (state_d == ST_EXPOSE);
    adc_reset_d  = (state_d == ST_ADC_CLR);
    adc_enable_d = (state_d == ST_CONVERT);
    valid_d      = (state_d == ST_OUTPUT);
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_DONE);
    dsel_d       = '0;
    if (state_d inside {ST_SETTLE, ST_ADC_CLR, ST_CONVERT, ST_OUTPUT})
      dsel_d = idx_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      data_q       <= '0;
      pidx_q       <= '0;
      err_q        <= 1'b0;
      erase_q      <= 1'b0;
      expose_q     <= 1'b0;
      dsel_q       <= '0;
      adc_reset_q  <= 1'b0;
      adc_enable_q <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      pidx_q       <= pidx_d;
      err_q        <= err_d;
      erase_q      <= erase_d;
      expose_q     <= expose_d;
      dsel_q       <= dsel_d;
      adc_reset_q  <= adc_reset_d;
      adc_enable_q <= adc_enable_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ERASE           = erase_q;
  assign EXPOSE          = expose_q;
  assign decoder_select  = dsel_q;
  assign adc_reset       = adc_reset_q;
  assign adc_enable      = adc_enable_q;
  assign busy            = busy_q;
  assign frame_done      = frame_done_q;
  assign pix.pixel_data  = data_q;
  assign pix.pixel_index = pidx_q;
  assign pix.pixel_error = err_q;
  assign pix.pixel_valid = valid_q;

endmodule

// File: tb/tb_pixel_readout_sequencer.sv
// Directed bench for pixel_readout_sequencer with a small behavioural ADC model.
module tb_pixel_readout_sequencer;

  localparam int WIDTH = 2;
  localparam int RES   = 8;

  logic             clk;
  logic             reset;
  logic             start;
  logic [15:0]      expose_time;
  logic             ERASE, EXPOSE, adc_reset, adc_enable, busy, frame_done;
  logic [WIDTH:0]   decoder_select;
  logic [RES-1:0]   adc_output;
  logic             adc_done;

  pixel_readout_sequencer_if #(.WIDTH(WIDTH), .RESOLUTION(RES)) pif ();

  pixel_readout_sequencer #(
    .WIDTH(WIDTH), .ROWS(2), .RESOLUTION(RES),
    .ERASE_CYCLES(4), .SETTLE_CYCLES(2), .ADC_TIMEOUT(64)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .expose_time(expose_time),
    .ERASE(ERASE), .EXPOSE(EXPOSE), .decoder_select(decoder_select),
    .adc_reset(adc_reset), .adc_enable(adc_enable),
    .adc_output(adc_output), .adc_done(adc_done),
    .pix(pif), .busy(busy), .frame_done(frame_done)
  );

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor and ADC model; everything sampled on the falling edge.
  int adc_mode = 0;   // 0: done on 9th enable cycle, 1: never, 2: done on 64th
  int cyc = 0, erase_cnt = 0, expose_cnt = 0, fd_cnt = 0, en_cnt = 0;
  logic [RES-1:0] q_data[$];
  logic [WIDTH:0] q_idx[$];
  logic           q_err[$];
  int             q_cyc[$];
  int             en_len[$];

  always @(negedge clk) begin
    cyc++;
    if (ERASE === 1'b1)      erase_cnt++;
    if (EXPOSE === 1'b1)     expose_cnt++;
    if (frame_done === 1'b1) fd_cnt++;
    if (pif.pixel_valid === 1'b1 && pif.pixel_ready === 1'b1) begin
      q_data.push_back(pif.pixel_data);
      q_idx.push_back(pif.pixel_index);
      q_err.push_back(pif.pixel_error);
      q_cyc.push_back(cyc);
    end
    if (adc_enable === 1'b1) en_cnt++;
    else begin
      if (en_cnt != 0) en_len.push_back(en_cnt);
      en_cnt = 0;
    end
    adc_done   = (adc_enable === 1'b1) &&
                 ((adc_mode == 0 && en_cnt == 9) || (adc_mode == 2 && en_cnt == 64));
    adc_output = (decoder_select == 3'd0) ? 8'h5A : 8'hC3;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input int maxc, output bit ok);
    int k = 0;
    while (busy !== 1'b0 && k < maxc) begin
      tick();
      k++;
    end
    ok = (busy === 1'b0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [21:0] all_out;
    reset = 1'b0;
    tick(2);
    all_out = {ERASE, EXPOSE, decoder_select, adc_reset, adc_enable, pif.pixel_data,
               pif.pixel_index, pif.pixel_error, pif.pixel_valid, busy, frame_done};
    checks++;
    if (all_out !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", all_out);
    end
    reset = 1'b1;
    tick(2);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_basic_frame();
    int b = q_data.size(), be = en_len.size();
    int e0 = erase_cnt, x0 = expose_cnt, f0 = fd_cnt;
    bit ok;
    expose_time = 16'd10;
    adc_mode = 0;
    pif.pixel_ready = 1'b1;
    pulse_start();
    checks++;
    if (ERASE !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_latency: ERASE=%b busy=%b required 1 1", ERASE, busy);
    end
    wait_idle(500, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout: busy=%b required 0", busy); end
    checks++;
    if (erase_cnt - e0 != 4) begin errors++; $display("FAIL basic_erase_len: got %0d required 4", erase_cnt - e0); end
    checks++;
    if (expose_cnt - x0 != 10) begin errors++; $display("FAIL basic_expose_len: got %0d required 10", expose_cnt - x0); end
    checks++;
    if (fd_cnt - f0 != 1) begin errors++; $display("FAIL basic_frame_done: got %0d required 1", fd_cnt - f0); end
    checks++;
    if (q_data.size() - b != 2) begin
      errors++;
      $display("FAIL basic_sample_count: got %0d required 2", q_data.size() - b);
    end else begin
      checks++;
      if ({q_data[b], q_data[b+1]} !== 16'h5AC3) begin
        errors++;
        $display("FAIL basic_data: got %h %h required 5a c3", q_data[b], q_data[b+1]);
      end
      checks++;
      if (q_idx[b] !== 3'd0 || q_idx[b+1] !== 3'd1) begin
        errors++;
        $display("FAIL basic_index: got %0d %0d required 0 1", q_idx[b], q_idx[b+1]);
      end
      checks++;
      if (q_err[b] !== 1'b0 || q_err[b+1] !== 1'b0) begin
        errors++;
        $display("FAIL basic_error: got %b %b required 0 0", q_err[b], q_err[b+1]);
      end
      checks++;
      if (q_cyc[b+1] - q_cyc[b] != 13) begin
        errors++;
        $display("FAIL basic_pixel_latency: got %0d required 13", q_cyc[b+1] - q_cyc[b]);
      end
    end
    checks++;
    if (en_len.size() - be != 2 || en_len[en_len.size()-1] != 9) begin
      errors++;
      $display("FAIL basic_enable_len: got %0d entries required 2 of 9", en_len.size() - be);
    end
    checks++;
    if (decoder_select !== 3'd0) begin
      errors++;
      $display("FAIL basic_select_idle: got %0d required 0", decoder_select);
    end
  endtask

  task automatic test_ready_stall();
    int b = q_data.size(), f0 = fd_cnt, k = 0;
    bit ok;
    expose_time = 16'd3;
    adc_mode = 0;
    pif.pixel_ready = 1'b0;
    pulse_start();
    while (pif.pixel_valid !== 1'b1 && k < 200) begin tick(); k++; end
    checks++;
    if (pif.pixel_valid !== 1'b1) begin errors++; $display("FAIL stall_valid_wait: valid=%b required 1", pif.pixel_valid); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (pif.pixel_valid !== 1'b1 || pif.pixel_data !== 8'h5A || adc_enable !== 1'b0 ||
          pif.pixel_index !== 3'd0 || decoder_select !== 3'd0) begin
        errors++;
        $display("FAIL stall_hold_%0d: valid=%b data=%h en=%b idx=%0d sel=%0d required 1 5a 0 0 0",
                 i, pif.pixel_valid, pif.pixel_data, adc_enable, pif.pixel_index, decoder_select);
      end
    end
    pif.pixel_ready = 1'b1;
    wait_idle(500, ok);
    checks++;
    if (!ok || q_data.size() - b != 2 || fd_cnt - f0 != 1) begin
      errors++;
      $display("FAIL stall_completion: samples=%0d frames=%0d required 2 1", q_data.size() - b, fd_cnt - f0);
    end else begin
      checks++;
      if ({q_data[b], q_data[b+1]} !== 16'h5AC3) begin
        errors++;
        $display("FAIL stall_data: got %h %h required 5a c3", q_data[b], q_data[b+1]);
      end
    end
  endtask

  task automatic test_timeout();
    int b = q_data.size(), be = en_len.size();
    bit ok;
    expose_time = 16'd3;
    adc_mode = 1;
    pif.pixel_ready = 1'b1;
    pulse_start();
    wait_idle(1000, ok);
    checks++;
    if (!ok || q_data.size() - b != 2) begin
      errors++;
      $display("FAIL timeout_samples: got %0d required 2", q_data.size() - b);
    end else begin
      checks++;
      if (q_data[b] !== 8'h00 || q_data[b+1] !== 8'h00 || q_err[b] !== 1'b1 || q_err[b+1] !== 1'b1) begin
        errors++;
        $display("FAIL timeout_data: got %h/%b %h/%b required 00/1 00/1",
                 q_data[b], q_err[b], q_data[b+1], q_err[b+1]);
      end
      checks++;
      if (q_idx[b+1] !== 3'd1) begin errors++; $display("FAIL timeout_next_index: got %0d required 1", q_idx[b+1]); end
    end
    checks++;
    if (en_len.size() - be != 2 || en_len[be] != 64 || en_len[be+1] != 64) begin
      errors++;
      $display("FAIL timeout_enable_len: entries=%0d required 2 of 64", en_len.size() - be);
    end
    adc_mode = 0;
  endtask

  task automatic test_expose_zero();
    int e0 = erase_cnt, x0 = expose_cnt, f0 = fd_cnt, k = 0;
    bit ok;
    expose_time = 16'd0;
    adc_mode = 0;
    pulse_start();
    while (EXPOSE !== 1'b1 && k < 50) begin tick(); k++; end
    pulse_start();
    wait_idle(500, ok);
    tick(5);
    checks++;
    if (!ok || busy !== 1'b0) begin errors++; $display("FAIL expose0_single_frame: busy=%b required 0", busy); end
    checks++;
    if (expose_cnt - x0 != 1) begin errors++; $display("FAIL expose0_len: got %0d required 1", expose_cnt - x0); end
    checks++;
    if (erase_cnt - e0 != 4 || fd_cnt - f0 != 1) begin
      errors++;
      $display("FAIL expose0_ignored_start: erase=%0d frames=%0d required 4 1", erase_cnt - e0, fd_cnt - f0);
    end
  endtask

  task automatic test_mid_reset();
    logic [21:0] all_out;
    int f0, b, k = 0;
    bit ok;
    expose_time = 16'd2;
    adc_mode = 0;
    pulse_start();
    while (!(adc_enable === 1'b1 && decoder_select === 3'd1) && k < 300) begin tick(); k++; end
    checks++;
    if (adc_enable !== 1'b1) begin errors++; $display("FAIL midreset_reach_convert: en=%b required 1", adc_enable); end
    f0 = fd_cnt;
    reset = 1'b0;
    #1;
    all_out = {ERASE, EXPOSE, decoder_select, adc_reset, adc_enable, pif.pixel_data,
               pif.pixel_index, pif.pixel_error, pif.pixel_valid, busy, frame_done};
    checks++;
    if (all_out !== 22'd0) begin errors++; $display("FAIL midreset_outputs: got %h required 0", all_out); end
    tick(3);
    reset = 1'b1;
    tick(3);
    checks++;
    if (fd_cnt != f0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_done: frames=%0d busy=%b required 0 0", fd_cnt - f0, busy);
    end
    b = q_data.size();
    pulse_start();
    wait_idle(500, ok);
    checks++;
    if (!ok || q_data.size() - b != 2 || fd_cnt - f0 != 1) begin
      errors++;
      $display("FAIL midreset_new_frame: samples=%0d frames=%0d required 2 1", q_data.size() - b, fd_cnt - f0);
    end else begin
      checks++;
      if (q_idx[b] !== 3'd0 || q_idx[b+1] !== 3'd1 || q_data[b] !== 8'h5A || q_data[b+1] !== 8'hC3 ||
          q_err[b] !== 1'b0 || q_err[b+1] !== 1'b0) begin
        errors++;
        $display("FAIL midreset_clean_samples: idx %0d %0d data %h %h required 0 1 5a c3",
                 q_idx[b], q_idx[b+1], q_data[b], q_data[b+1]);
      end
    end
  endtask

  task automatic test_done_at_timeout();
    int b = q_data.size(), be = en_len.size();
    bit ok;
    expose_time = 16'd1;
    adc_mode = 2;
    pulse_start();
    wait_idle(1000, ok);
    checks++;
    if (!ok || q_data.size() - b != 2) begin
      errors++;
      $display("FAIL edge_samples: got %0d required 2", q_data.size() - b);
    end else begin
      checks++;
      if (q_data[b] !== 8'h5A || q_data[b+1] !== 8'hC3 || q_err[b] !== 1'b0 || q_err[b+1] !== 1'b0) begin
        errors++;
        $display("FAIL edge_capture: got %h/%b %h/%b required 5a/0 c3/0",
                 q_data[b], q_err[b], q_data[b+1], q_err[b+1]);
      end
    end
    checks++;
    if (en_len.size() - be != 2 || en_len[be] != 64) begin
      errors++;
      $display("FAIL edge_enable_len: entries=%0d required 2 of 64", en_len.size() - be);
    end
    adc_mode = 0;
  endtask

  task automatic test_back_to_back();
    int k = 0;
    bit ok;
    expose_time = 16'd1;
    adc_mode = 0;
    start = 1'b1;
    while (frame_done !== 1'b1 && k < 300) begin tick(); k++; end
    checks++;
    if (frame_done !== 1'b1) begin errors++; $display("FAIL b2b_frame_done: got %b required 1", frame_done); end
    tick();
    checks++;
    if (busy !== 1'b0 || ERASE !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_gap: busy=%b ERASE=%b required 0 0", busy, ERASE);
    end
    tick();
    checks++;
    if (busy !== 1'b1 || ERASE !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart: busy=%b ERASE=%b required 1 1", busy, ERASE);
    end
    start = 1'b0;
    wait_idle(500, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_second_frame: busy=%b required 0", busy); end
  endtask

  initial begin
    reset           = 1'b0;
    start           = 1'b0;
    expose_time     = 16'd0;
    pif.pixel_ready = 1'b0;
    test_reset();
    test_basic_frame();
    test_ready_stall();
    test_timeout();
    test_expose_zero();
    test_mid_reset();
    test_done_at_timeout();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_readout_sequencer.md
# pixel_readout_sequencer

Frame-level controller driving one pixel column/row block from the initiator side: it generates the ERASE/EXPOSE phases, steps the row-select code through every pixel, starts and supervises each SAR conversion, and hands each digitised sample downstream over a valid/ready handshake. It sits between the image-sensor top level and the pixel-row/SAR-ADC datapath, and is the only owner of `decoder_select`, `ERASE`, `EXPOSE`, ADC reset and ADC enable.

## Interface
Parameters:
- `WIDTH`, 2: select-code width parameter; `decoder_select` is `WIDTH+1` bits.
- `ROWS`, 2: pixels read per frame, 1..2**WIDTH.
- `RESOLUTION`, 8: ADC result width.
- `ERASE_CYCLES`, 4: clock cycles ERASE is held high.
- `SETTLE_CYCLES`, 2: cycles between select change and ADC start.
- `ADC_TIMEOUT`, 64: max cycles waiting for `adc_done`.

Ports (clock and reset first):
- `clk` in 1: single clock; all logic rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: frame request, sampled only in IDLE.
- `expose_time` in 16: exposure length in cycles, latched on accepted `start`; 0 treated as 1.
- `ERASE` out 1: pixel erase strobe.
- `EXPOSE` out 1: pixel expose strobe.
- `decoder_select` out WIDTH+1: row/pixel select to the mux.
- `adc_reset` out 1: active-high one-cycle ADC clear.
- `adc_enable` out 1: ADC conversion enable.
- `adc_output` in RESOLUTION: ADC result.
- `adc_done` in 1: ADC conversion complete.
- `pixel_data` out RESOLUTION: captured sample.
- `pixel_index` out WIDTH+1: select code the sample came from.
- `pixel_error` out 1: sample produced by timeout (data forced to 0).
- `pixel_valid` out 1 / `pixel_ready` in 1: output handshake.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle pulse after last pixel accepted.

## Operation
- States: IDLE, ERASE, EXPOSE, SETTLE, ADC_CLR, CONVERT, OUTPUT, DONE.
- IDLE: `start`=1 → latch `expose_time`, index←0, go ERASE. `start` ignored in all other states.
- ERASE: `ERASE`=1 for exactly ERASE_CYCLES cycles → EXPOSE.
- EXPOSE: `EXPOSE`=1 for exactly max(expose_time,1) cycles → SETTLE.
- SETTLE: `decoder_select`=index, held SETTLE_CYCLES cycles → ADC_CLR.
- ADC_CLR: `adc_reset`=1 one cycle → CONVERT; timeout counter cleared.
- CONVERT: `adc_enable`=1; first cycle `adc_done`=1 → capture `adc_output`, error=0 → OUTPUT. Counter reaching ADC_TIMEOUT first → data=0, error=1 → OUTPUT. `adc_done` sampled in the same cycle as the timeout wins (capture, no error).
- OUTPUT: `pixel_valid`=1; `pixel_data`/`pixel_index`/`pixel_error` stable until `pixel_valid && pixel_ready`. On transfer: index==ROWS-1 → DONE, else index+1 → SETTLE.
- DONE: `frame_done`=1 one cycle → IDLE.
- `decoder_select` holds the current index from SETTLE through OUTPUT; 0 in IDLE.
- Counters sized by $clog2 of their maximum; exposure counter 16 bits, no wrap (terminal compare).

## Timing
- Reset (asynchronous assert, any state): state IDLE; all outputs 0 (`ERASE`, `EXPOSE`, `decoder_select`, `adc_reset`, `adc_enable`, `pixel_*`, `busy`, `frame_done`). Mid-frame reset abandons the frame; no `frame_done`.
- All outputs registered; `start` high in cycle N → `ERASE`=1 and `busy`=1 from cycle N+1.
- `adc_done` at cycle M → `adc_enable`=0 and `pixel_valid`=1 at M+1.
- `pixel_ready` held high: per-pixel latency SETTLE_CYCLES + 1 + conversion + 1 cycles; no gaps beyond that.
- `pixel_valid` never drops without a transfer; `pixel_ready` ignored when `pixel_valid`=0.
- `start` high continuously: new frame starts the cycle after DONE returns to IDLE (one IDLE cycle).

## Structure
- Shared package `sensor_pkg`: state enum `seq_state_t`, default RESOLUTION/WIDTH constants, shared with the pixel-row and SAR-ADC blocks.
- One sub-module natural: `cycle_timer` (load, count-down, terminal flag) reused for ERASE, EXPOSE, SETTLE and timeout.

## Test plan
- Defaults, `expose_time`=10, ADC model done 9 cycles after enable, ready=1: ERASE high 4 cycles, EXPOSE 10, two samples indices 0,1 with model values 0x5A,0xC3, `frame_done` pulse once.
- `pixel_ready` low 5 cycles in OUTPUT: `pixel_valid` and data 0x5A held constant, `adc_enable` stays 0, index not advanced.
- ADC model never asserts done: after 64 CONVERT cycles sample emitted with data 0, `pixel_error`=1; frame continues to index 1.
- `expose_time`=0: EXPOSE high exactly 1 cycle; `start` pulsed during EXPOSE ignored (single frame).
- `reset` low in CONVERT of index 1: all outputs 0 within same cycle, no `frame_done`; new `start` runs a full clean frame from index 0.
- `adc_done` coincident with timeout terminal cycle: sample captured, `pixel_error`=0.
